// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small show-ahead receive FIFO.
// A two-flop synchroniser feeds a five-state bit-timing FSM. Completed
// bytes are pushed into a FIFO whose head is presented combinationally
// on q. Sticky overrun and frameErr flags report dropped bytes and bad
// stop bits until software clears them.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uartRxPin,
  input  logic       re,
  input  logic       clearErr,
  output logic [7:0] q,
  output logic       ready,
  output logic       full,
  output logic       busy,
  output logic       overrun,
  output logic       frameErr
);

  // Counter and pointer geometry.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  // Count values at which the FSM acts: mid start bit, and end of a bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Pointer difference that means "full": only the wrap bit differs.
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic rxs;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uartRxPin;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             push;
  logic             frame_set;

  // Next-state logic: bit timing, data capture and stop-bit verdict.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end

      S_START: begin
        // Re-check the line half a bit in; a high here was a glitch.
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = rxs ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        // One full bit period after the previous centre is the next centre.
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d        = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        // Hold here while the line stays low so a break counts only once.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  assign ready = (wp_q != rp_q);
  assign full  = ((wp_q ^ rp_q) == FULL_XOR);

  // Pointer and flag updates. A simultaneous pop frees the slot a push
  // needs, so a push into a full FIFO is only dropped without a pop.
  always_comb begin
    pop   = re && ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wp_d = wp_q + PW'(wr_en);
    rp_d = rp_q + PW'(pop);

    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clearErr) begin
      overrun_d = 1'b0;
    end

    frame_err_d = frame_err_q;
    if (frame_set) begin
      frame_err_d = 1'b1;
    end else if (clearErr) begin
      frame_err_d = 1'b0;
    end
  end

  // FIFO pointers and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage array; contents are meaningless until the pointers cover them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wp_q[AW-1:0]] <= shift_q;
    end
  end

  assign q        = ready ? mem[rp_q[AW-1:0]] : 8'h00;
  assign overrun  = overrun_q;
  assign frameErr = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with 16 clocks per bit and a
// 4-entry FIFO. Expected values are hand-derived from the frame timing.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       uartRxPin = 1'b1;
  logic       re        = 1'b0;
  logic       clearErr  = 1'b0;
  logic [7:0] q;
  logic       ready;
  logic       full;
  logic       busy;
  logic       overrun;
  logic       frameErr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .uartRxPin(uartRxPin),
    .re       (re),
    .clearErr (clearErr),
    .q        (q),
    .ready    (ready),
    .full     (full),
    .busy     (busy),
    .overrun  (overrun),
    .frameErr (frameErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n clocks, leaving time 1 unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one 8N1 frame, LSB first; stop_bit lets a bad stop be sent.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    uartRxPin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uartRxPin = data[i];
      tick(CPB);
    end
    uartRxPin = stop_bit;
    tick(CPB);
  endtask

  // Check the head entry, then pop it with a one-clock re pulse.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, q, exp);
    re = 1'b1;
    tick(1);
    re = 1'b0;
  endtask

  task automatic clear_flags();
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  lat;
  int  lat_obs;
  logic seen_busy;

  initial begin
    // Reset values, sampled while reset is held.
    tick(3);
    check("rst_q", q, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frameErr", frameErr, 1'b0);
    reset = 1'b1;
    tick(1);

    // Idle line: busy must never rise.
    seen_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (busy) seen_busy = 1'b1;
    end
    check("idle_busy", seen_busy, 1'b0);

    // Single frame: ready expected 155 edges after the drive point
    // (t0 is the next edge, then 2 + 8 + 144).
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!ready && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    lat_obs = (lat >= 154 && lat <= 156) ? 155 : lat;
    check("a5_latency", lat_obs, 155);
    check("a5_ready", ready, 1'b1);
    check("a5_q", q, 8'hA5);
    check("a5_busy_done", busy, 1'b0);
    re = 1'b1;
    tick(1);
    re = 1'b0;
    check("a5_pop_ready", ready, 1'b0);
    check("a5_pop_q", q, 8'h00);

    // Five back-to-back frames, no reads: fourth fills, fifth overruns.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check("fill4_full", full, 1'b1);
    check("fill4_overrun", overrun, 1'b0);
    send_frame(8'h05, 1'b1);
    check("fill5_overrun", overrun, 1'b1);
    check("fill5_full", full, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check("fifo_order", 8'(i));
    check("drain_ready", ready, 1'b0);
    check("drain_full", full, 1'b0);
    clear_flags();
    check("clr_overrun", overrun, 1'b0);

    // Bad stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0);
    tick(100);
    check("brk_frameErr", frameErr, 1'b1);
    check("brk_ready", ready, 1'b0);
    check("brk_busy_low", busy, 1'b1);
    uartRxPin = 1'b1;
    tick(4);
    check("brk_busy_high", busy, 1'b0);
    send_frame(8'h7E, 1'b1);
    check("after_brk_ready", ready, 1'b1);
    pop_check("after_brk_q", 8'h7E);
    check("frameErr_sticky", frameErr, 1'b1);
    clear_flags();
    check("clr_frameErr", frameErr, 1'b0);

    // Four-clock glitch: FSM enters START, then abandons it.
    uartRxPin = 1'b0;
    tick(4);
    uartRxPin = 1'b1;
    tick(1);
    check("glitch_busy", busy, 1'b1);
    tick(30);
    check("glitch_idle", busy, 1'b0);
    check("glitch_ready", ready, 1'b0);
    check("glitch_overrun", overrun, 1'b0);
    check("glitch_frameErr", frameErr, 1'b0);

    // Full FIFO, pop coincident with the fifth frame's stop sample.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(154);
        re = 1'b1;
        tick(1);
        re = 1'b0;
      end
    join
    check("simul_overrun", overrun, 1'b0);
    check("simul_full", full, 1'b1);
    for (int i = 2; i <= 5; i++) pop_check("simul_order", 8'(i));
    check("simul_ready", ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
